// File: rtl/count_checker.sv
// rtl/count_checker.sv - registered-counter checker with self-resync prediction and saturating error count
//
// Purpose:
//   Watches an external up/down counter (count, en, up_dn) and predicts its next
//   value each cycle. The prediction is always rebuilt from the observed count, so
//   one bad sample yields one error and the checker resyncs on the following edge.
//   The first edge after reset release checks that the counter came out of reset at 0.
//
// Parameters:
//   N      width of the observed count bus
//   ERR_W  width of each event counter output
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   en         observed counter enable
//   up_dn      observed direction (1 = up, 0 = down)
//   count      observed registered counter value
//   exp_count  predicted value of count for the current cycle
//   locked     high while the checker is in LOCKED
//   err        registered one-cycle-per-mismatch flag
//   err_cnt    saturating mismatch count
//   up_wrap_cnt, dn_wrap_cnt  (only with COUNT_CHECKER_WRAP_EN) saturating counts
//              of matched up-wraps (max -> 0) and down-wraps (0 -> max)
//
// Configuration macro: COUNT_CHECKER_WRAP_EN

module count_checker #(
    parameter int N     = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic [N-1:0]     count,
    output logic [N-1:0]     exp_count,
    output logic             locked,
    output logic             err,
`ifdef COUNT_CHECKER_WRAP_EN
    output logic [ERR_W-1:0] up_wrap_cnt,
    output logic [ERR_W-1:0] dn_wrap_cnt,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        RST_CHK = 2'b00,
        LOCKED  = 2'b01,
        ERR     = 2'b10
    } state_e;

    localparam logic [N-1:0]     CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] EV_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [N-1:0]     exp_count_q, exp_count_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch;
    logic             tracking;

    // Next-state logic and comparison
    always_comb begin
        state_d  = RST_CHK;
        mismatch = 1'b0;
        tracking = 1'b0;
        unique case (state_q)
            RST_CHK: begin
                // Counter must leave reset at zero
                mismatch = (count != '0);
                state_d  = mismatch ? ERR : LOCKED;
            end
            LOCKED, ERR: begin
                tracking = 1'b1;
                mismatch = (count != exp_count_q);
                state_d  = mismatch ? ERR : LOCKED;
            end
            default: begin
                state_d = RST_CHK;
            end
        endcase
    end

    // Prediction is taken from the observed count, never from the old prediction
    always_comb begin
        exp_count_d = count;
        if (en) begin
            exp_count_d = up_dn ? (count + CNT_ONE) : (count - CNT_ONE);
        end
    end

    always_comb begin
        err_d     = mismatch;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + EV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_CHK;
            exp_count_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_count_q <= exp_count_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign exp_count = exp_count_q;
    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef COUNT_CHECKER_WRAP_EN
    // A wrap is counted on the edge that confirms it: the previous edge predicted
    // a wrap (pend flag) and the count now sampled matches that prediction.
    logic             up_pend_q, up_pend_d;
    logic             dn_pend_q, dn_pend_d;
    logic [ERR_W-1:0] up_wrap_q, up_wrap_d;
    logic [ERR_W-1:0] dn_wrap_q, dn_wrap_d;

    always_comb begin
        up_pend_d = en &  up_dn & (count == '1);
        dn_pend_d = en & ~up_dn & (count == '0);
        up_wrap_d = up_wrap_q;
        dn_wrap_d = dn_wrap_q;
        if (tracking && !mismatch && up_pend_q && (up_wrap_q != '1)) begin
            up_wrap_d = up_wrap_q + EV_ONE;
        end
        if (tracking && !mismatch && dn_pend_q && (dn_wrap_q != '1)) begin
            dn_wrap_d = dn_wrap_q + EV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_pend_q <= 1'b0;
            dn_pend_q <= 1'b0;
            up_wrap_q <= '0;
            dn_wrap_q <= '0;
        end else begin
            up_pend_q <= up_pend_d;
            dn_pend_q <= dn_pend_d;
            up_wrap_q <= up_wrap_d;
            dn_wrap_q <= dn_wrap_d;
        end
    end

    assign up_wrap_cnt = up_wrap_q;
    assign dn_wrap_cnt = dn_wrap_q;
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking bench for count_checker (vector table, hand sequences, random vs model)

module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic [7:0] count = 8'd0;

    logic [7:0]  exp_count_a, exp_count_b;
    logic        locked_a, locked_b, err_a, err_b;
    logic [15:0] err_cnt_a;
    logic [1:0]  err_cnt_b;
`ifdef COUNT_CHECKER_WRAP_EN
    logic [15:0] upw_a, dnw_a;
    logic [1:0]  upw_b, dnw_b;
`endif

    always #5 clk = ~clk;

    count_checker #(.N(8), .ERR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .count(count),
        .exp_count(exp_count_a), .locked(locked_a), .err(err_a),
`ifdef COUNT_CHECKER_WRAP_EN
        .up_wrap_cnt(upw_a), .dn_wrap_cnt(dnw_a),
`endif
        .err_cnt(err_cnt_a)
    );

    count_checker #(.N(8), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .count(count),
        .exp_count(exp_count_b), .locked(locked_b), .err(err_b),
`ifdef COUNT_CHECKER_WRAP_EN
        .up_wrap_cnt(upw_b), .dn_wrap_cnt(dnw_b),
`endif
        .err_cnt(err_cnt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural reference: "first edge" flag plus the value the counter should show next
    bit m_first;
    int m_pred, m_err, m_locked, m_cnt_a, m_cnt_b;
    bit m_upw_next, m_dnw_next;
    int m_upw_a, m_dnw_a, m_upw_b, m_dnw_b;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_first = 1; m_pred = 0; m_err = 0; m_locked = 0; m_cnt_a = 0; m_cnt_b = 0;
        m_upw_next = 0; m_dnw_next = 0; m_upw_a = 0; m_dnw_a = 0; m_upw_b = 0; m_dnw_b = 0;
    endtask

    task automatic model_edge(input bit e, input bit u, input int c);
        bit bad_edge;
        int step_v;
        bad_edge = m_first ? (c != 0) : (c != m_pred);
        if (!m_first && !bad_edge) begin
            if (m_upw_next) begin m_upw_a = sat(m_upw_a + 1, 65535); m_upw_b = sat(m_upw_b + 1, 3); end
            if (m_dnw_next) begin m_dnw_a = sat(m_dnw_a + 1, 65535); m_dnw_b = sat(m_dnw_b + 1, 3); end
        end
        m_upw_next = e && u && (c == 255);
        m_dnw_next = e && !u && (c == 0);
        step_v   = !e ? 0 : (u ? 1 : -1);
        m_pred   = (c + 256 + step_v) % 256;
        m_first  = 0;
        m_err    = bad_edge;
        m_locked = !bad_edge;
        if (bad_edge) begin
            m_cnt_a = sat(m_cnt_a + 1, 65535);
            m_cnt_b = sat(m_cnt_b + 1, 3);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".err"},       int'(err_a),       m_err);
        chk({tag, ".locked"},    int'(locked_a),    m_locked);
        chk({tag, ".exp_count"}, int'(exp_count_a), m_pred);
        chk({tag, ".err_cnt"},   int'(err_cnt_a),   m_cnt_a);
        chk({tag, ".err_cnt_w2"},int'(err_cnt_b),   m_cnt_b);
        chk({tag, ".err_w2"},    int'(err_b),       m_err);
`ifdef COUNT_CHECKER_WRAP_EN
        chk({tag, ".up_wrap"},   int'(upw_a), m_upw_a);
        chk({tag, ".dn_wrap"},   int'(dnw_a), m_dnw_a);
        chk({tag, ".up_wrap_w2"},int'(upw_b), m_upw_b);
        chk({tag, ".dn_wrap_w2"},int'(dnw_b), m_dnw_b);
`endif
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later
    task automatic step(input bit r, input bit e, input bit u, input int c);
        @(negedge clk);
        rst_n = r; en = e; up_dn = u; count = 8'(c);
        @(posedge clk);
        #1;
        if (r) model_edge(e, u, c);
        else   model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; count = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
    endtask

    typedef struct {
        bit e; bit u; int c;
        int x_err; int x_locked; int x_exp; int x_cnt;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit e, input bit u, input int c,
                       input int xe, input int xl, input int xx, input int xc);
        vec_t v;
        v.e = e; v.u = u; v.c = c; v.x_err = xe; v.x_locked = xl; v.x_exp = xx; v.x_cnt = xc;
        vt.push_back(v);
    endtask

    initial begin
        // Clean up-count from reset: 0..16, locked from the first edge
        for (int i = 0; i <= 16; i++) add(1, 1, i, 0, 1, i + 1, 0);
        // Single bad sample (0x20 where 0x11 expected) then resync from 0x20
        add(1, 1, 8'h20, 1, 0, 8'h21, 1);
        add(1, 1, 8'h21, 0, 1, 8'h22, 1);
        add(1, 1, 8'h22, 0, 1, 8'h23, 1);
        // Jump to 0xFE (mismatch), then legal up-wrap FF -> 00
        add(1, 1, 8'hFE, 1, 0, 8'hFF, 2);
        add(1, 1, 8'hFF, 0, 1, 8'h00, 2);
        add(1, 1, 8'h00, 0, 1, 8'h01, 2);
        // Turn round, legal down-wrap 00 -> FF, then hold
        add(1, 0, 8'h01, 0, 1, 8'h00, 2);
        add(1, 0, 8'h00, 0, 1, 8'hFF, 2);
        add(1, 0, 8'hFF, 0, 1, 8'hFE, 2);
        add(0, 0, 8'hFE, 0, 1, 8'hFE, 2);
        add(0, 1, 8'hFE, 0, 1, 8'hFE, 2);

        // Reset state
        do_reset();
        chk("rst.err", int'(err_a), 0);
        chk("rst.locked", int'(locked_a), 0);
        chk("rst.exp_count", int'(exp_count_a), 0);
        chk("rst.err_cnt", int'(err_cnt_a), 0);

        foreach (vt[i]) begin
            step(1, vt[i].e, vt[i].u, vt[i].c);
            chk($sformatf("vec%0d.err", i),       int'(err_a),       vt[i].x_err);
            chk($sformatf("vec%0d.locked", i),    int'(locked_a),    vt[i].x_locked);
            chk($sformatf("vec%0d.exp_count", i), int'(exp_count_a), vt[i].x_exp);
            chk($sformatf("vec%0d.err_cnt", i),   int'(err_cnt_a),   vt[i].x_cnt);
        end
`ifdef COUNT_CHECKER_WRAP_EN
        chk("wrap.up_wrap_cnt", int'(upw_a), 1);
        chk("wrap.dn_wrap_cnt", int'(dnw_a), 1);
`endif

        // Counter stuck at 0x05 out of reset, recovers once en=0 makes it match
        do_reset();
        step(1, 1, 1, 5);
        chk("stuck.err", int'(err_a), 1);
        chk("stuck.locked", int'(locked_a), 0);
        chk("stuck.err_cnt", int'(err_cnt_a), 1);
        step(0 == 1 ? 0 : 1, 0, 1, 5);
        chk("stuck2.err", int'(err_a), 1);
        chk("stuck2.err_cnt", int'(err_cnt_a), 2);
        step(1, 0, 1, 5);
        chk("stuck3.locked", int'(locked_a), 1);
        chk("stuck3.err", int'(err_a), 0);
        chk("stuck3.exp_count", int'(exp_count_a), 5);

        // Four back-to-back mismatches on the 2-bit error counter: 1,2,3,3
        do_reset();
        begin
            int seq_c[4]   = '{7, 8, 7, 8};
            int seq_cnt[4] = '{1, 2, 3, 3};
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 0, seq_c[i]);
                chk($sformatf("sat%0d.err_w2", i), int'(err_b), 1);
                chk($sformatf("sat%0d.err_cnt_w2", i), int'(err_cnt_b), seq_cnt[i]);
                chk($sformatf("sat%0d.err_cnt", i), int'(err_cnt_a), i + 1);
            end
        end

        // Asynchronous reset while in ERR with the 2-bit counter at 3
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.err", int'(err_b), 0);
        chk("areset.err_cnt_w2", int'(err_cnt_b), 0);
        chk("areset.err_cnt", int'(err_cnt_a), 0);
        chk("areset.locked", int'(locked_b), 0);
        chk("areset.exp_count", int'(exp_count_b), 0);
        model_reset();
        step(1, 1, 1, 0);
        chk("areset_rel.locked", int'(locked_b), 1);
        chk("areset_rel.err", int'(err_b), 0);
        chk("areset_rel.exp_count", int'(exp_count_b), 1);

        // Randomized run against the reference model
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit r, e, u;
            int c;
            r = ($urandom_range(0, 63) != 0);
            e = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 1);
            if (m_first) c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : 0;
            else if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: c = 0;
                    1: c = 255;
                    2: c = 1;
                    3: c = 254;
                    default: c = $urandom_range(0, 255);
                endcase
            end else c = m_pred;
            step(r, e, u, c);
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
